// File: rtl/weight_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | weight_pkg : shared widths, tensor selects and requester IDs         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package weight_pkg;

  localparam int SEL_W  = 6;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;
  localparam int N_REQ  = 4;

  localparam logic [SEL_W-1:0] SEL_TOK_EMB    = 6'd0;
  localparam logic [SEL_W-1:0] SEL_POS_EMB    = 6'd1;
  localparam logic [SEL_W-1:0] SEL_LAYER_BASE = 6'd2;
  localparam int               SEL_PER_LAYER  = 6;
  // Offsets added to SEL_LAYER_BASE + layer*SEL_PER_LAYER
  localparam logic [SEL_W-1:0] SEL_OFS_LN1    = 6'd0;
  localparam logic [SEL_W-1:0] SEL_OFS_QKV    = 6'd1;
  localparam logic [SEL_W-1:0] SEL_OFS_ATTN_O = 6'd2;
  localparam logic [SEL_W-1:0] SEL_OFS_LN2    = 6'd3;
  localparam logic [SEL_W-1:0] SEL_OFS_MLP_UP = 6'd4;
  localparam logic [SEL_W-1:0] SEL_OFS_MLP_DN = 6'd5;

  typedef enum logic [1:0] {
    REQ_EMBED = 2'd0,
    REQ_ATTN  = 2'd1,
    REQ_MLP   = 2'd2,
    REQ_HEAD  = 2'd3
  } req_id_e;

  function automatic logic [2:0] oh_to_idx(input logic [7:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) idx = idx | 3'(i);
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_pick : combinational round-robin pick (rotate/encode/unrotate)    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module rr_pick #(
  parameter int N     = 4,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic             valid
);

  logic [N-1:0] w_rot;
  logic [N-1:0] w_rot_gnt;

  always_comb begin
    w_rot = '0;
    for (int i = 0; i < N; i++) begin
      int j;
      j = int'(ptr) + i;
      if (j >= N) j = j - N;
      w_rot[i] = req[PTR_W'(j)];
    end
  end

  // Isolate the lowest set bit of the rotated request vector
  assign w_rot_gnt = w_rot & (~w_rot + N'(1));

  always_comb begin
    gnt = '0;
    for (int p = 0; p < N; p++) begin
      int j;
      j = int'(ptr) + p;
      if (j >= N) j = j - N;
      gnt[PTR_W'(j)] = w_rot_gnt[p];
    end
  end

  assign valid = |req;

endmodule
`default_nettype wire

// File: rtl/weight_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | weight_arbiter : round-robin read-port arbiter with burst lock       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module weight_arbiter #(
  parameter int N_REQ  = weight_pkg::N_REQ,
  parameter int SEL_W  = weight_pkg::SEL_W,
  parameter int ADDR_W = weight_pkg::ADDR_W,
  parameter int DATA_W = weight_pkg::DATA_W
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [N_REQ-1:0]          req_i,
  input  logic [N_REQ-1:0]          lock_i,
  input  logic [N_REQ*SEL_W-1:0]    sel_i,
  input  logic [N_REQ*ADDR_W-1:0]   addr_i,
  output logic [N_REQ-1:0]          gnt_o,
  output logic [N_REQ-1:0]          rvalid_o,
  output logic [DATA_W-1:0]         rdata_o,
  output logic [SEL_W-1:0]          w_sel_o,
  output logic [ADDR_W-1:0]         w_addr_o,
  input  logic [DATA_W-1:0]         w_data_i,
  output logic                      busy_o
);
  import weight_pkg::*;

  localparam int PTR_W = $clog2(N_REQ);

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] owner_q, owner_d;
  logic             locked_q, locked_d;
  logic [N_REQ-1:0] rv_q;

  logic [N_REQ-1:0] w_rr_gnt;
  logic             w_rr_valid;
  logic [N_REQ-1:0] w_own_oh;
  logic             w_any_gnt;
  logic [PTR_W-1:0] w_gnt_idx;

  rr_pick #(
    .N     (N_REQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .req   (req_i),
    .ptr   (ptr_q),
    .gnt   (w_rr_gnt),
    .valid (w_rr_valid)
  );

  // A held lock masks the round-robin pick entirely, even while the owner idles
  always_comb begin
    w_own_oh          = '0;
    w_own_oh[owner_q] = 1'b1;
    gnt_o             = locked_q ? (req_i & w_own_oh) : w_rr_gnt;
    w_any_gnt         = locked_q ? req_i[owner_q] : w_rr_valid;
    w_gnt_idx         = PTR_W'(oh_to_idx(8'(gnt_o)));
  end

  always_comb begin
    w_sel_o  = '0;
    w_addr_o = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (gnt_o[k]) begin
        w_sel_o  = sel_i[k*SEL_W +: SEL_W];
        w_addr_o = addr_i[k*ADDR_W +: ADDR_W];
      end
    end
  end

  always_comb begin
    ptr_d    = ptr_q;
    locked_d = locked_q;
    owner_d  = owner_q;
    if (w_any_gnt) begin
      ptr_d = (w_gnt_idx == PTR_W'(N_REQ - 1)) ? '0 : w_gnt_idx + PTR_W'(1);
    end
    if (!locked_q) begin
      if (w_any_gnt && lock_i[w_gnt_idx]) begin
        locked_d = 1'b1;
        owner_d  = w_gnt_idx;
      end
    end else if (!lock_i[owner_q]) begin
      locked_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q    <= '0;
      owner_q  <= '0;
      locked_q <= 1'b0;
      rv_q     <= '0;
    end else begin
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      locked_q <= locked_d;
      rv_q     <= gnt_o;
    end
  end

  assign rvalid_o = rv_q;
  assign rdata_o  = w_data_i;
  assign busy_o   = locked_q;

endmodule
`default_nettype wire

// File: tb/tb_weight_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_weight_arbiter : vector table, directed bursts and random traffic |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_weight_arbiter;

  localparam int N  = 4;
  localparam int SW = 6;
  localparam int AW = 16;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req;
  logic [N-1:0]    lock;
  logic [N*SW-1:0] sel;
  logic [N*AW-1:0] addr;
  logic [N-1:0]    gnt;
  logic [N-1:0]    rvalid;
  logic [DW-1:0]   rdata;
  logic [SW-1:0]   w_sel;
  logic [AW-1:0]   w_addr;
  logic [DW-1:0]   w_data = '0;
  logic            busy;

  int n_chk  = 0;
  int n_pass = 0;

  int          m_ptr, m_owner, m_rv;
  bit          m_locked;
  logic [5:0]  m_rsel;
  logic [15:0] m_raddr;

  weight_arbiter #(.N_REQ(N), .SEL_W(SW), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .req_i    (req),
    .lock_i   (lock),
    .sel_i    (sel),
    .addr_i   (addr),
    .gnt_o    (gnt),
    .rvalid_o (rvalid),
    .rdata_o  (rdata),
    .w_sel_o  (w_sel),
    .w_addr_o (w_addr),
    .w_data_i (w_data),
    .busy_o   (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_f(input logic [5:0] s, input logic [15:0] a);
    return 8'((int'(s) * 29 + int'(a) * 7 + (int'(a) >> 8)) & 255);
  endfunction

  // One-cycle-latency weight store
  always @(posedge clk) w_data <= mem_f(w_sel, w_addr);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic model_reset();
    m_ptr = 0; m_owner = 0; m_rv = -1; m_locked = 0;
    m_rsel = '0; m_raddr = '0;
  endtask

  function automatic int model_pick(input logic [N-1:0] r);
    if (m_locked) return r[m_owner] ? m_owner : -1;
    for (int i = 0; i < N; i++) begin
      if (r[(m_ptr + i) % N]) return (m_ptr + i) % N;
    end
    return -1;
  endfunction

  // Called at posedge+1; drives inputs, checks mid-cycle, advances model
  task automatic tick(input logic [N-1:0] r, input logic [N-1:0] l,
                      output logic [N-1:0] g_seen, output logic b_seen);
    int g;
    logic [N-1:0]  eg, erv;
    logic [SW-1:0] es;
    logic [AW-1:0] ea;
    req = r; lock = l;
    @(negedge clk);
    g   = model_pick(r);
    eg  = (g >= 0) ? (N'(1) << g) : '0;
    es  = (g >= 0) ? sel[g*SW +: SW] : '0;
    ea  = (g >= 0) ? addr[g*AW +: AW] : '0;
    erv = (m_rv >= 0) ? (N'(1) << m_rv) : '0;
    chk("gnt", 32'(gnt), 32'(eg));
    chk("w_sel", 32'(w_sel), 32'(es));
    chk("w_addr", 32'(w_addr), 32'(ea));
    chk("rvalid", 32'(rvalid), 32'(erv));
    if (m_rv >= 0) chk("rdata", 32'(rdata), 32'(mem_f(m_rsel, m_raddr)));
    chk("busy", 32'(busy), 32'(m_locked));
    g_seen = gnt;
    b_seen = busy;
    @(posedge clk);
    m_rv = g;
    if (g >= 0) begin
      m_rsel  = sel[g*SW +: SW];
      m_raddr = addr[g*AW +: AW];
      m_ptr   = (g + 1) % N;
    end
    if (!m_locked) begin
      if (g >= 0 && l[g]) begin m_locked = 1; m_owner = g; end
    end else if (!l[m_owner]) begin
      m_locked = 0;
    end
    #1;
  endtask

  typedef struct {
    logic [N-1:0] req;
    logic [N-1:0] lock;
    logic [N-1:0] gnt;
    logic         busy;
  } vec_t;

  vec_t tbl[20];

  initial begin
    logic [N-1:0] g;
    logic         b;

    tbl[0]  = '{4'b0011, 4'b0000, 4'b0001, 1'b0};
    tbl[1]  = '{4'b0011, 4'b0000, 4'b0010, 1'b0};
    tbl[2]  = '{4'b0011, 4'b0000, 4'b0001, 1'b0};
    tbl[3]  = '{4'b1111, 4'b0000, 4'b0010, 1'b0};
    tbl[4]  = '{4'b1111, 4'b0000, 4'b0100, 1'b0};
    tbl[5]  = '{4'b1111, 4'b0000, 4'b1000, 1'b0};
    tbl[6]  = '{4'b1111, 4'b0000, 4'b0001, 1'b0};
    tbl[7]  = '{4'b1000, 4'b0000, 4'b1000, 1'b0};
    tbl[8]  = '{4'b0000, 4'b0000, 4'b0000, 1'b0};
    tbl[9]  = '{4'b0110, 4'b0000, 4'b0010, 1'b0};
    tbl[10] = '{4'b0100, 4'b0100, 4'b0100, 1'b0};
    tbl[11] = '{4'b1011, 4'b1000, 4'b0000, 1'b1};
    tbl[12] = '{4'b1011, 4'b0000, 4'b1000, 1'b0};
    tbl[13] = '{4'b0001, 4'b0001, 4'b0001, 1'b0};
    tbl[14] = '{4'b0010, 4'b0011, 4'b0000, 1'b1};
    tbl[15] = '{4'b0011, 4'b0011, 4'b0001, 1'b1};
    tbl[16] = '{4'b0011, 4'b0010, 4'b0001, 1'b1};
    tbl[17] = '{4'b0011, 4'b0010, 4'b0010, 1'b0};
    tbl[18] = '{4'b0011, 4'b0000, 4'b0010, 1'b1};
    tbl[19] = '{4'b0000, 4'b0000, 4'b0000, 1'b0};

    rst_n = 1'b0; req = '0; lock = '0; sel = '0; addr = '0;
    model_reset();
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b1;
    #3;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_rvalid", 32'(rvalid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_wsel", 32'(w_sel), 32'h0);
    chk("rst_waddr", 32'(w_addr), 32'h0);
    @(posedge clk); #1;
    tick('0, '0, g, b);

    for (int i = 0; i < 20; i++) begin
      for (int k = 0; k < N; k++) begin
        sel[k*SW +: SW]  = SW'(k + 2);
        addr[k*AW +: AW] = AW'(i * 16 + k);
      end
      tick(tbl[i].req, tbl[i].lock, g, b);
      chk($sformatf("tbl%0d_gnt", i), 32'(g), 32'(tbl[i].gnt));
      chk($sformatf("tbl%0d_busy", i), 32'(b), 32'(tbl[i].busy));
    end

    // Single back-to-back stream from requester 0
    for (int a = 0; a < 128; a++) begin
      sel[0 +: SW]  = '0;
      addr[0 +: AW] = AW'(a);
      tick(4'b0001, '0, g, b);
      chk("stream_gnt", 32'(g), 32'h1);
    end
    tick('0, '0, g, b);

    // Locked 256-word burst against a competing requester 2
    tick(4'b1000, '0, g, b);
    sel[2*SW +: SW]  = 6'd5;
    addr[2*AW +: AW] = 16'h0055;
    for (int i = 0; i < 256; i++) begin
      sel[0 +: SW]  = (i < 128) ? 6'd0 : 6'd1;
      addr[0 +: AW] = AW'(i % 128);
      tick(4'b0101, (i < 255) ? 4'b0001 : 4'b0000, g, b);
      chk("burst_gnt", 32'(g), 32'h1);
      if (i > 0) chk("burst_busy", 32'(b), 32'h1);
    end
    tick(4'b0100, '0, g, b);
    chk("post_lock_gnt", 32'(g), 32'h4);

    // Wrap-around with all requesters active
    tick(4'b1000, '0, g, b);
    for (int i = 0; i < 8; i++) begin
      tick(4'b1111, '0, g, b);
      chk("wrap_gnt", 32'(g), 32'(4'b0001 << (i % 4)));
    end

    // Reset right after a grant drops the pending return
    tick(4'b0010, '0, g, b);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("midrst_rvalid", 32'(rvalid), 32'h0);
    chk("midrst_busy", 32'(busy), 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick('0, '0, g, b);
    tick(4'b1100, '0, g, b);
    chk("post_rst_gnt", 32'(g), 32'h4);

    // Random traffic against the reference model
    for (int i = 0; i < 3000; i++) begin
      sel  = (N*SW)'({$urandom, $urandom});
      addr = (N*AW)'({$urandom, $urandom});
      tick(N'($urandom), N'($urandom & $urandom & $urandom), g, b);
    end
    tick('0, '0, g, b);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
